// File: rtl/ofifo_pkg.sv
// Shared constants and helpers for the de-skewing output buffer.
package ofifo_pkg;
    localparam int COL_D   = 8;
    localparam int BW_D    = 22;
    localparam int DEPTH_D = 16;

    // Ceiling log2, used to size the lane pointer index.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Bit offset of a lane inside a packed row.
    function automatic int lane_lo(input int lane, input int bw);
        return lane * bw;
    endfunction
endpackage

// File: rtl/ofifo_col_if.sv
// Row bus between the mac_col outputs, this buffer and the normalisation stage.
interface ofifo_col_if
    import ofifo_pkg::*;
#(
    parameter int COL = COL_D,
    parameter int BW  = BW_D
);
    logic [COL-1:0]    wr;
    logic [COL*BW-1:0] in;
    logic              rd;
    logic [COL*BW-1:0] out;
    logic              out_valid;
    logic              o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output wr, in, rd,
        input  out, out_valid, o_valid, o_full, o_ready, o_overflow, o_underflow
    );
    modport slave (
        input  wr, in, rd,
        output out, out_valid, o_valid, o_full, o_ready, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_lane.sv
// One lane FIFO; head entry is visible combinationally on dout.
module fifo_lane
    import ofifo_pkg::*;
#(
    parameter int BW    = BW_D,
    parameter int DEPTH = DEPTH_D
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [BW-1:0] din,
    input  logic          rd,      // already gated: only high on an accepted row read
    output logic [BW-1:0] dout,
    output logic          empty,
    output logic          full
);
    localparam int AW = clog2(DEPTH);

    logic [BW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;

    assign empty = (r_wp == r_rp);
    assign full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign dout  = r_mem[r_rp[AW-1:0]];

    // Pointer update; a write into a full lane is dropped (the top flags it).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (wr && !full) r_wp <= r_wp + 1'b1;
            if (rd)          r_rp <= r_rp + 1'b1;
        end
    end

    // Storage array needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr && !full) r_mem[r_wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ofifo_col.sv
// De-skews COL staggered psum lanes and hands out one aligned row per read.
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int COL   = COL_D,
    parameter int BW    = BW_D,
    parameter int DEPTH = DEPTH_D
) (
    input  logic         clk,
    input  logic         reset,
    ofifo_col_if.slave   bus
);
    logic [COL-1:0]    w_empty;
    logic [COL-1:0]    w_full;
    logic [COL*BW-1:0] w_head;
    logic              w_valid;
    logic              w_rd_ok;
    logic [COL*BW-1:0] r_out;
    logic              r_out_valid;
    logic              r_ovf;
    logic              r_udf;

    // Flags come from registered pointers only, never from this cycle's wr/rd.
    assign w_valid = ~|w_empty;
    assign w_rd_ok = bus.rd && w_valid;

    for (genvar g = 0; g < COL; g++) begin : g_lane
        localparam int LO = lane_lo(g, BW);
        fifo_lane #(.BW(BW), .DEPTH(DEPTH)) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (bus.wr[g]),
            .din   (bus.in[LO +: BW]),
            .rd    (w_rd_ok),
            .dout  (w_head[LO +: BW]),
            .empty (w_empty[g]),
            .full  (w_full[g])
        );
    end

    // Row output register: loads all lane heads together on an accepted read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_rd_ok;
            if (w_rd_ok) r_out <= w_head;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (|(bus.wr & w_full))   r_ovf <= 1'b1;
            if (bus.rd && !w_valid)   r_udf <= 1'b1;
        end
    end

    assign bus.out         = r_out;
    assign bus.out_valid   = r_out_valid;
    assign bus.o_valid     = w_valid;
    assign bus.o_full      = |w_full;
    assign bus.o_ready     = ~|w_full;
    assign bus.o_overflow  = r_ovf;
    assign bus.o_underflow = r_udf;
endmodule

// File: tb/tb_ofifo_col.sv
// Self-checking bench for ofifo_col against a queue-based row model.
module tb_ofifo_col;
    import ofifo_pkg::*;
    localparam int COL = COL_D;
    localparam int BW  = BW_D;
    localparam int DEP = DEPTH_D;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ofifo_col_if #(.COL(COL), .BW(BW)) bus ();
    ofifo_col #(.COL(COL), .BW(BW), .DEPTH(DEP)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // Reference: one queue per lane, plus the visible output register and sticky flags.
    logic [BW-1:0]     q [COL][$];
    logic [COL*BW-1:0] m_out;
    logic              m_ov, m_ovf, m_udf;

    function automatic logic m_valid();
        for (int i = 0; i < COL; i++) if (q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int i = 0; i < COL; i++) if (q[i].size() == DEP) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [5:0] m_flags();
        return {m_ov, m_valid(), m_full(), ~m_full(), m_ovf, m_udf};
    endfunction

    function automatic logic [5:0] d_flags();
        return {bus.out_valid, bus.o_valid, bus.o_full, bus.o_ready, bus.o_overflow, bus.o_underflow};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < COL; i++) q[i].delete();
        m_out = '0; m_ov = 0; m_ovf = 0; m_udf = 0;
    endtask

    // Occupancy is judged on the state before the edge; reads pop before writes push.
    task automatic model_edge(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
        int  sz [COL];
        logic v;
        v = m_valid();
        for (int i = 0; i < COL; i++) sz[i] = q[i].size();
        m_ov = 0;
        if (r) begin
            if (v) begin
                for (int i = 0; i < COL; i++) m_out[i*BW +: BW] = q[i].pop_front();
                m_ov = 1;
            end else m_udf = 1;
        end
        for (int i = 0; i < COL; i++)
            if (w[i]) begin
                if (sz[i] == DEP) m_ovf = 1;
                else q[i].push_back(d[i*BW +: BW]);
            end
    endtask

    // Drive at the falling edge, clock once, sample at the next falling edge.
    task automatic tick(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
        bus.wr = w; bus.in = d; bus.rd = r;
        @(posedge clk);
        model_edge(w, d, r);
        @(negedge clk);
        bus.wr = '0; bus.rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [COL*BW-1:0] row_of(input int base);
        logic [COL*BW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(base + i);
        return r;
    endfunction

    function automatic logic [COL*BW-1:0] rand_row();
        logic [COL*BW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_vec++;
        if (d_flags() !== 6'b000100) begin
            n_err++; $display("FAIL reset_flags got=%b exp=000100", d_flags());
        end
        n_vec++;
        if (bus.out !== '0) begin n_err++; $display("FAIL reset_out got=%h exp=0", bus.out); end
    endtask

    task automatic test_wavefront(input int base);
        for (int i = 0; i < COL; i++) begin
            tick(COL'(1) << i, row_of(base), 1'b0);
            n_vec++;
            if (bus.o_valid !== (i == COL-1)) begin
                n_err++; $display("FAIL wave_valid lane=%0d got=%b exp=%b", i, bus.o_valid, i == COL-1);
            end
        end
        tick('0, '0, 1'b1);
        n_vec++;
        if (bus.out !== row_of(base) || bus.out_valid !== 1'b1 || bus.o_valid !== 1'b0) begin
            n_err++; $display("FAIL wave_row got=%h ov=%b v=%b exp=%h", bus.out, bus.out_valid, bus.o_valid, row_of(base));
        end
        tick('0, '0, 1'b0);
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.out !== row_of(base)) begin
            n_err++; $display("FAIL wave_pulse ov=%b out=%h", bus.out_valid, bus.out);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < DEP; k++) tick(8'h08, rand_row(), 1'b0);
        n_vec++;
        if (bus.o_full !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_full got full=%b rdy=%b ovf=%b exp 1 0 0", bus.o_full, bus.o_ready, bus.o_overflow);
        end
        tick(8'h08, {COL{22'h3FFFFF}}, 1'b0);
        n_vec++;
        if (bus.o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", bus.o_overflow); end
        for (int k = 0; k < DEP; k++) tick(8'hF7, rand_row(), 1'b0);
        for (int k = 0; k < DEP; k++) begin
            tick('0, '0, 1'b1);
            n_vec++;
            if (bus.out !== m_out || bus.out[3*BW +: BW] === 22'h3FFFFF) begin
                n_err++; $display("FAIL ovf_row%0d got=%h exp=%h", k, bus.out, m_out);
            end
        end
        n_vec++;
        if (d_flags() !== m_flags()) begin n_err++; $display("FAIL ovf_end got=%b exp=%b", d_flags(), m_flags()); end
    endtask

    task automatic test_underflow();
        do_reset();
        tick(8'h7F, rand_row(), 1'b0);
        tick('0, '0, 1'b1);
        n_vec++;
        if (bus.out !== '0 || bus.out_valid !== 1'b0 || bus.o_underflow !== 1'b1) begin
            n_err++; $display("FAIL udf got out=%h ov=%b udf=%b exp 0 0 1", bus.out, bus.out_valid, bus.o_underflow);
        end
        tick(8'h80, rand_row(), 1'b0);
        tick('0, '0, 1'b1);
        n_vec++;
        if (bus.out !== m_out || bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL udf_read got=%h exp=%h", bus.out, m_out);
        end
    endtask

    task automatic test_steady();
        do_reset();
        tick('1, row_of(0), 1'b0);
        for (int c = 1; c <= 40; c++) begin
            tick('1, row_of(8*c), 1'b1);
            n_vec++;
            if (bus.out !== row_of(8*(c-1)) || d_flags() !== 6'b110100) begin
                n_err++; $display("FAIL steady c=%0d out=%h flags=%b exp=%h 110100", c, bus.out, d_flags(), row_of(8*(c-1)));
            end
        end
        tick('0, '0, 1'b1);
        n_vec++;
        if (bus.out !== row_of(320) || d_flags() !== 6'b100100) begin
            n_err++; $display("FAIL steady_drain out=%h flags=%b", bus.out, d_flags());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            tick(COL'($urandom), rand_row(), 1'($urandom_range(0, 2) == 0));
            n_vec++;
            if (bus.out !== m_out || d_flags() !== m_flags()) begin
                n_err++; $display("FAIL rand c=%0d out=%h flags=%b exp=%h %b", c, bus.out, d_flags(), m_out, m_flags());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 5; k++) tick('1, rand_row(), 1'b0);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_reset v=%b rdy=%b exp 0 1", bus.o_valid, bus.o_ready);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        test_wavefront(200);
    endtask

    initial begin
        bus.wr = '0; bus.in = '0; bus.rd = 1'b0;
        model_clear();
        test_reset();
        test_wavefront(100);
        test_overflow();
        test_underflow();
        test_steady();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
